// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. The block takes one bit per clock, LSB first,
// through a single full adder and a carry flop. It uses a start/done handshake.
// A new operation is accepted in IDLE or DONE. The result appears WIDTH cycles
// after the edge that sampled start, and done pulses for that one cycle.
//
// Parameters:
//   WIDTH  operand/result width in bits (1..32)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   start  in   request; sampled only in IDLE or DONE
//   sub    in   0 = a+b, 1 = a-b (sampled with start)
//   a, b   in   operands (sampled with start)
//   busy   out  high while the serial computation runs (SHIFT)
//   done   out  one-cycle pulse when sum/cout/ovf update
//   sum    out  result modulo 2^WIDTH, held until the next completion
//   cout   out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_part;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_part_next;

    // Full adder acting on the current LSBs of the operand shift registers.
    assign w_s = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_c = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);

    // The partial result shifts right and the new sum bit enters at the MSB.
    // After WIDTH shifts, bit 0 of the result has reached bit 0 of the register.
    // Written as shift-then-overwrite so that WIDTH = 1 needs no special case.
    // NOTE: always_comb must assign every output before any conditional or
    // partial update. Otherwise a latch is inferred.
    always_comb begin
        w_part_next              = r_part >> 1;
        w_part_next[WIDTH-1]     = w_s;
    end

    // NOTE: every register in this block, including the operand and partial
    // shift registers, is assigned non-blocking. Each flop then samples the
    // value held before the edge, no matter where it sits in the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1. The +1 is the initial carry.
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                SHIFT: begin
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_part  <= w_part_next;
                    r_carry <= w_c;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        // On the MSB cycle, r_carry is still the carry into the
                        // MSB, so overflow is carry-in XOR carry-out here.
                        sum     <= w_part_next;
                        cout    <= w_c;
                        ovf     <= r_carry ^ w_c;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Self-checking bench for serial_addsub. It instantiates the block at WIDTH 8,
// 4 and 1. Each result is compared with an integer-arithmetic reference model.
// The bench also checks start-to-done latency, the busy duration, back-to-back
// throughput, that start is ignored mid-operation, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic       start8 = 1'b0, sub8 = 1'b0, busy8, done8, cout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start4 = 1'b0, sub4 = 1'b0, busy4, done4, cout4, ovf4;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       start1 = 1'b0, sub1 = 1'b0, busy1, done1, cout1, ovf1;
    logic [0:0] a1 = '0, b1 = '0, sum1;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );
    serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );
    serial_addsub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain unsigned and signed integer arithmetic at width w.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] es,
                                  output logic ec, output logic eo);
        longint m, half, ua, ub, sa, sb, r, sr;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (!s) begin
            r  = ua + ub;
            ec = (r >= m);
            sr = sa + sb;
        end else begin
            r  = ua - ub + m;
            ec = (ua >= ub);
            sr = sa - sb;
        end
        es = 32'(r % m);
        eo = (sr < -half) || (sr >= half);
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] av,
                         input logic [31:0] bv, input logic sv);
        start8 = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        case (w)
            8: begin start8 = st; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; end
            4: begin start4 = st; a4 = av[3:0]; b4 = bv[3:0]; sub4 = sv; end
            default: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; sub1 = sv; end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : (w == 4) ? done4 : done1;
    endfunction
    function automatic logic [31:0] get_sum(input int w);
        return (w == 8) ? {24'b0, sum8} : (w == 4) ? {28'b0, sum4} : {31'b0, sum1};
    endfunction
    function automatic logic get_cout(input int w);
        return (w == 8) ? cout8 : (w == 4) ? cout4 : cout1;
    endfunction
    function automatic logic get_ovf(input int w);
        return (w == 8) ? ovf8 : (w == 4) ? ovf4 : ovf1;
    endfunction

    // Called at a negedge. Asserts start there and runs one operation to done.
    // Returns at the negedge where done is high, so a back-to-back caller can
    // assert its start in the DONE cycle. If inject >= 0, start is pulsed with
    // junk operands after inject SHIFT cycles. That start must be ignored.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int inject);
        logic [31:0] es;
        logic        ec, eo;
        int          n, busy_n;
        model(w, a, b, s, es, ec, eo);
        drive(w, 1'b1, a, b, s);
        @(negedge clk);
        n      = 0;
        busy_n = 0;
        while (!get_done(w) && n < 4 * w + 8) begin
            if (get_busy(w)) busy_n++;
            if (n == inject)
                drive(w, 1'b1, $urandom, $urandom, 1'($urandom));
            else
                drive(w, 1'b0, a, b, s);
            @(negedge clk);
            n++;
        end
        check($sformatf("w%0d latency", w), n, w);
        check($sformatf("w%0d busy cycles", w), busy_n, w);
        check($sformatf("w%0d busy at done", w), {31'b0, get_busy(w)}, 0);
        check($sformatf("w%0d sum %0h%s%0h", w, a, s ? "-" : "+", b), get_sum(w), es);
        check($sformatf("w%0d cout %0h%s%0h", w, a, s ? "-" : "+", b), {31'b0, get_cout(w)}, {31'b0, ec});
        check($sformatf("w%0d ovf %0h%s%0h", w, a, s ? "-" : "+", b), {31'b0, get_ovf(w)}, {31'b0, eo});
    endtask

    task automatic check_all_zero(input string tag);
        for (int w = 1; w <= 8; w++) begin
            if (w == 1 || w == 4 || w == 8) begin
                check($sformatf("%s w%0d busy", tag, w), {31'b0, get_busy(w)}, 0);
                check($sformatf("%s w%0d done", tag, w), {31'b0, get_done(w)}, 0);
                check($sformatf("%s w%0d sum", tag, w), get_sum(w), 0);
                check($sformatf("%s w%0d cout", tag, w), {31'b0, get_cout(w)}, 0);
                check($sformatf("%s w%0d ovf", tag, w), {31'b0, get_ovf(w)}, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors at WIDTH 8.
        @(negedge clk); run_op(8, 32'h5A, 32'h3C, 1'b0, -1);
        @(negedge clk);
        check("w8 done one cycle", {31'b0, done8}, 0);
        check("w8 sum held", {24'b0, sum8}, 32'h96);
        run_op(8, 32'h10, 32'h20, 1'b1, -1);
        @(negedge clk); run_op(8, 32'h20, 32'h10, 1'b1, -1);
        @(negedge clk); run_op(8, 32'hFF, 32'h01, 1'b0, -1);
        @(negedge clk); run_op(8, 32'h80, 32'h01, 1'b1, -1);

        // A start pulse during SHIFT must not disturb the running operation.
        @(negedge clk); run_op(8, 32'h5A, 32'h3C, 1'b0, 3);

        // Abort a subtraction (carry preloaded to 1) after four SHIFT cycles.
        @(negedge clk);
        drive(8, 1'b1, 32'hFF, 32'h00, 1'b1);
        @(negedge clk);
        drive(8, 1'b0, 32'h00, 32'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("w8 busy before abort", {31'b0, busy8}, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        // The new add must see no carry left over from the aborted subtraction.
        @(negedge clk); run_op(8, 32'h00, 32'h00, 1'b0, -1);

        // When reset and start are asserted together, reset must win.
        @(negedge clk);
        drive(8, 1'b1, 32'h12, 32'h34, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("w8 reset beats start", {31'b0, busy8}, 0);
        reset = 1'b0;
        drive(8, 1'b0, 32'h00, 32'h00, 1'b0);
        @(negedge clk);
        check("w8 idle after reset", {31'b0, busy8}, 0);

        // Random WIDTH 8 traffic, mixing idle gaps, back-to-back starts and
        // ignored mid-SHIFT starts.
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            run_op(8, $urandom, $urandom, 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // WIDTH 4 and WIDTH 1, back-to-back on every DONE cycle.
        @(negedge clk);
        run_op(4, 32'h9, 32'h8, 1'b0, -1);
        run_op(4, 32'h9, 32'h8, 1'b0, -1);
        for (int i = 0; i < 12; i++) run_op(4, $urandom, $urandom, 1'($urandom), -1);
        @(negedge clk);
        @(negedge clk);
        run_op(1, 32'h1, 32'h1, 1'b0, -1);
        run_op(1, 32'h1, 32'h1, 1'b0, -1);
        for (int i = 0; i < 8; i++) run_op(1, $urandom, $urandom, 1'($urandom), -1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor with a start/done handshake. It replaces the fixed 4-bit serial adder in the arithmetic datapath, adding configurable width, a subtract mode, signed-overflow detection and a clean one-cycle completion pulse. Each operation processes one bit per clock, LSB first, through a single full adder and a carry flop. This trades latency for area in the serial-arithmetic units.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse; sampled only when the block can accept a new operation (IDLE or DONE).
- sub  in  1  mode, sampled with start: 0 = a+b, 1 = a−b.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when the result registers update.
- sum  out  WIDTH  result; held until the next completion.
- cout  out  1  carry out of the MSB; in subtract mode, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, SHIFT, DONE.
- **Reset (asynchronous):**
  - state = IDLE, count = 0, carry = 0.
  - Internal shift registers cleared.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
- **IDLE or DONE with start = 1:**
  - Load opA ← a and opB ← (sub ? ~b : b).
  - carry ← sub; count ← 0; state → SHIFT.
- **IDLE with start = 0:** stay in IDLE.
- **DONE with start = 0:** go to IDLE.
- **SHIFT, each cycle:**
  - s = opA[0] ^ opB[0] ^ carry; c = majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1.
  - The partial-result register shifts right, with s entering at the MSB.
  - carry ← c; count ← count + 1.
  - On the cycle where count = WIDTH−1, also record the carry into the MSB (the carry value before this cycle's update).
- **SHIFT exit (count = WIDTH−1):**
  - state → DONE.
  - sum ← final partial result; cout ← c; ovf ← carry_in_msb ^ c.
  - done = 1 for the DONE cycle.
- **Start when not accepted:** start in SHIFT is ignored. No queueing; a, b and sub are don't-care at that point.
- **Output stability:** sum, cout and ovf change only on the SHIFT→DONE transition. Partial results are never visible on sum.
- **Width rules:**
  - Arithmetic is modulo 2^WIDTH.
  - count width is clog2(WIDTH+1).
  - WIDTH = 1 completes in a single SHIFT cycle.

## Timing
- Let edge 0 be the clock edge that samples start.
- Edges 1..WIDTH: SHIFT cycles; busy = 1 after edges 0..WIDTH−1.
- After edge WIDTH: state DONE, done = 1, busy = 0, results valid.
- Start-to-done latency: WIDTH cycles.
- Back-to-back operation:
  - start asserted during the DONE cycle is accepted at edge WIDTH+1.
  - done and busy are never high together.
  - Sustained throughput: one operation per WIDTH+1 cycles.
- Reset mid-SHIFT aborts the operation immediately. No done pulse is generated, and all outputs return to their reset values.
- Reset asserted coincident with start: reset wins.

## Test plan
- WIDTH=8, add 0x5A+0x3C → done exactly 8 cycles after start; sum=0x96, cout=0, ovf=1.
- WIDTH=8, sub 0x10−0x20 → sum=0xF0, cout=0 (borrow), ovf=0. Then sub 0x20−0x10 → sum=0x10, cout=1, ovf=0.
- WIDTH=8, add 0xFF+0x01 → sum=0x00, cout=1, ovf=0. Also 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- Pulse start mid-SHIFT with different operands → ignored; first result correct; busy stays high for exactly 8 cycles.
- Assert reset at SHIFT cycle 4 → busy, done, sum, cout, ovf all 0 at once. A new start afterwards gives a correct result with no residual carry.
- WIDTH=4 and WIDTH=1 builds with back-to-back starts on each DONE cycle:
  - WIDTH=4, 0x9+0x8 → sum=0x1, cout=1, ovf=1; done every 5 cycles.
  - WIDTH=1, 1+1 → sum=0, cout=1, done every 2 cycles.
